rom_arbiter: RTL
================

Name: rom_arbiter

Overview:
- Shares one asynchronous 512K x 8 ROM/flash read port between two requesters: CPU (priority) and DMA/loader (background).
- Sequences each access: latches the address, drives output enable, waits a fixed access time, captures data and pulses a per-requester ready.
- A starvation guard stops CPU back-to-back traffic from locking out DMA indefinitely.
- Sits between the CPU/DMA fabric and the ROM pins; in simulation it drives the behavioural ROM model.

Parameters:
- ADDR_W, 19, ROM address width.
- DATA_W, 8, ROM data width.
- ACC_CYCLES, 3, cycles the address and output enable are held before data is sampled; must be >= 1.
- CPU_RUN_MAX, 4, maximum consecutive contested CPU grants before DMA is forced; must be >= 1.

Ports:
- fclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req  in  1  CPU read request; held high until cpu_rdy.
- cpu_addr  in  ADDR_W  CPU read address; stable while cpu_req is high.
- cpu_rdy  out  1  one-cycle pulse: cpu_data is valid.
- cpu_data  out  DATA_W  last byte read for the CPU; held between accesses.
- dma_req  in  1  DMA read request; same rules as cpu_req.
- dma_addr  in  ADDR_W  DMA read address.
- dma_rdy  out  1  one-cycle pulse: dma_data is valid.
- dma_data  out  DATA_W  last byte read for DMA; held.
- rom_addr  out  ADDR_W  ROM address, registered.
- rom_oe_n  out  1  ROM output enable, active-low, registered.
- rom_data  in  DATA_W  ROM read data.
- busy  out  1  high in ACCESS and RECOVER states.

Behaviour:
- Reset (rst_n low at an edge), including in the middle of an access:
  - state goes to IDLE;
  - rom_oe_n=1, rom_addr=0, cpu_rdy=dma_rdy=0, cpu_data=dma_data=8'hFF, cpu_run=0, owner=CPU;
  - an interrupted access produces no ready pulse.
- States are IDLE, ACCESS and RECOVER.
- IDLE:
  - Does nothing if no request is pending.
  - Otherwise it picks an owner, then loads rom_addr from that owner's address, sets rom_oe_n=0, loads cnt=ACC_CYCLES-1 and moves to ACCESS.
- Arbitration in IDLE:
  - Only one request pending: that requester wins.
  - Both pending and cpu_run < CPU_RUN_MAX: CPU wins and cpu_run increments.
  - Both pending and cpu_run == CPU_RUN_MAX: DMA wins.
  - A DMA grant clears cpu_run.
  - An uncontested CPU grant also clears cpu_run.
- ACCESS:
  - rom_addr and rom_oe_n are held; cnt decrements each cycle.
  - When cnt==0, rom_data is captured into the owner's data register.
  - In the same edge: the owner's rdy is set, rom_oe_n returns to 1, and the state moves to RECOVER.
- RECOVER:
  - Lasts exactly one cycle with the owner's rdy high; requests are ignored.
  - Then the state returns to IDLE and rdy returns to 0.
- Latency: request seen in IDLE at cycle 0 → rdy high at cycle ACC_CYCLES+1. Each access occupies ACC_CYCLES+2 cycles.
- Throughput: one byte per ACC_CYCLES+2 cycles.
- Requester protocol:
  - A requester drops req, or presents a new address, on the edge that ends RECOVER.
  - A req still high in IDLE is a new request.
- Address or req changes during ACCESS are ignored. If req drops in the middle of an access, the access still completes and rdy still pulses; the requester discards it.
- rom_addr holds its last value while idle; only rom_oe_n signals validity.
- cpu_rdy and dma_rdy are never high in the same cycle.

Decomposition:
- Shared package rom_arb_pkg:
  - state encoding: ST_IDLE, ST_ACCESS, ST_RECOVER;
  - owner encoding: OWN_CPU, OWN_DMA;
  - reset data value 8'hFF.
- Arbitration decision as a small sub-module rom_arb_pick:
  - inputs: cpu_req, dma_req, cpu_run, CPU_RUN_MAX;
  - output: grant owner;
  - the cpu_run register stays in the parent.
- Counter and FSM stay in rom_arbiter.

Test Plan:
1. Defaults (ACC_CYCLES=3), ROM model with mem[i]=i[7:0]. cpu_req=1, cpu_addr=19'h00012 at cycle 0 → rom_oe_n low cycles 1-3, rom_addr=19'h00012; cpu_rdy high only at cycle 4 with cpu_data=8'h12; dma_rdy stays 0.
2. cpu_req and dma_req both held high continuously → grant order CPU,CPU,CPU,CPU,DMA,CPU… (CPU_RUN_MAX=4); one DMA completion per 5 accesses, each access 5 cycles apart.
3. Only dma_req with addresses 19'h7FFFF then 19'h00000 back-to-back → dma_data=8'hFF then 8'h00; rdy pulses 5 cycles apart; cpu_data stays 8'hFF.
4. CPU access started; cpu_addr changed to 19'h00055 and cpu_req dropped at cycle 2 → rom_addr unchanged; cpu_rdy still pulses at cycle 4 with the original byte; the next IDLE starts no access.
5. rst_n low at cycle 2 of an access → next edge: rom_oe_n=1, rom_addr=0, no rdy pulse, data registers 8'hFF, busy=0; a fresh request after reset gives normal latency.
6. Rebuild with ACC_CYCLES=1, then drive one CPU request → rdy at cycle 2, rom_oe_n low exactly one cycle.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared encodings and constants for the ROM read-port arbiter.
package rom_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RECOVER
   } state_t;

   typedef enum logic {
      OWN_CPU,
      OWN_DMA
   } owner_t;

   localparam logic [7:0] DATA_RST = 8'hFF;

endpackage

// File: rtl/rom_arb_pick.sv
// Combinational owner selection: CPU has priority until its contested run limit is hit.
module rom_arb_pick
   import rom_arb_pkg::*;
#(
   parameter int unsigned CPU_RUN_MAX = 4,
   parameter int unsigned RUN_W       = 3
) (
   input  logic             cpu_req,
   input  logic             dma_req,
   input  logic [RUN_W-1:0] cpu_run,
   output owner_t           grant
);

   always_comb begin
      grant = OWN_CPU;
      if (dma_req && (!cpu_req || (cpu_run >= RUN_W'(CPU_RUN_MAX))))
         grant = OWN_DMA;
   end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one asynchronous ROM read port between a priority CPU and a background DMA,
// sequencing address/OE, a fixed access time, data capture and a per-requester ready.
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ACC_CYCLES  = 3,
   parameter int unsigned CPU_RUN_MAX = 4
) (
   input  logic              fclk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_rdy,
   output logic [DATA_W-1:0] cpu_data,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   output logic              dma_rdy,
   output logic [DATA_W-1:0] dma_data,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_oe_n,
   input  logic [DATA_W-1:0] rom_data,
   output logic              busy
);

   localparam int unsigned RUN_W = $clog2(CPU_RUN_MAX + 1);
   localparam int unsigned CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

   state_t           state;
   owner_t           owner;
   owner_t           grant;
   logic [RUN_W-1:0] cpu_run;
   logic [CNT_W-1:0] cnt;

   rom_arb_pick #(
      .CPU_RUN_MAX (CPU_RUN_MAX),
      .RUN_W       (RUN_W)
   ) u_pick (
      .cpu_req (cpu_req),
      .dma_req (dma_req),
      .cpu_run (cpu_run),
      .grant   (grant)
   );

   always_ff @(posedge fclk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         owner    <= OWN_CPU;
         cpu_run  <= '0;
         cnt      <= '0;
         rom_addr <= '0;
         rom_oe_n <= 1'b1;
         cpu_rdy  <= 1'b0;
         dma_rdy  <= 1'b0;
         cpu_data <= DATA_W'(DATA_RST);
         dma_data <= DATA_W'(DATA_RST);
         busy     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cpu_req || dma_req) begin
                  owner    <= grant;
                  rom_addr <= (grant == OWN_DMA) ? dma_addr : cpu_addr;
                  rom_oe_n <= 1'b0;
                  cnt      <= CNT_W'(ACC_CYCLES - 1);
                  busy     <= 1'b1;
                  state    <= ST_ACCESS;
                  // Only contested CPU grants extend the run; anything else restarts it.
                  if (grant == OWN_CPU && dma_req)
                     cpu_run <= cpu_run + RUN_W'(1);
                  else
                     cpu_run <= '0;
               end
            end

            ST_ACCESS: begin
               if (cnt == '0) begin
                  if (owner == OWN_DMA) begin
                     dma_data <= rom_data;
                     dma_rdy  <= 1'b1;
                  end else begin
                     cpu_data <= rom_data;
                     cpu_rdy  <= 1'b1;
                  end
                  rom_oe_n <= 1'b1;
                  state    <= ST_RECOVER;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end

            ST_RECOVER: begin
               cpu_rdy <= 1'b0;
               dma_rdy <= 1'b0;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
